pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// In-order pipeline controller: DEPTH stages of valid/data/halt registers with a
// combinational hold chain, per-stage flush, halt-on-retire and a retire counter.
module pipeline_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_halt,
   output logic                       in_ready,
   input  logic [DEPTH-1:0]           stall,
   input  logic [DEPTH-1:0]           flush,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_halt,
   output logic                       out_fire,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       halted,
   output logic [CNT_W-1:0]           retired
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_halt;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic             r_halted;
   logic [CNT_W-1:0] r_retired;

   logic [DEPTH:0]   w_hold;
   logic             w_in_ready;
   logic             w_fire;
   logic [OCC_W-1:0] w_occ;

   // Hold propagates upstream only through occupied, unflushed stages,
   // so empty or killed stages absorb a downstream stall.
   always_comb begin
      w_hold = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_hold[i] = r_valid[i] & ~flush[i] & (stall[i] | w_hold[i+1]);
      end
   end

   assign w_in_ready = ~w_hold[0] & ~r_halted;
   assign w_fire     = r_valid[DEPTH-1] & ~w_hold[DEPTH-1] & ~flush[DEPTH-1];

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ = w_occ + OCC_W'(r_valid[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid   <= '0;
         r_halt    <= '0;
         r_halted  <= 1'b0;
         r_retired <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         if (!w_hold[0]) begin
            r_valid[0] <= in_valid & w_in_ready;
            r_data[0]  <= in_data;
            r_halt[0]  <= in_halt;
         end
         // A held or flushed upstream stage hands a bubble downstream.
         for (int i = 1; i < DEPTH; i++) begin
            if (!w_hold[i]) begin
               r_valid[i] <= r_valid[i-1] & ~w_hold[i-1] & ~flush[i-1];
               r_data[i]  <= r_data[i-1];
               r_halt[i]  <= r_halt[i-1];
            end
         end
         if (w_fire) begin
            r_retired <= r_retired + 1'b1;
            if (r_halt[DEPTH-1]) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign out_halt  = r_halt[DEPTH-1];
   assign out_fire  = w_fire;
   assign occupancy = w_occ;
   assign halted    = r_halted;
   assign retired   = r_retired;

endmodule
